// File: rtl/adbg_lint_mem_target.sv
// LINT target: word-addressed scratch memory with byte enables, programmable
// grant wait-states and out-of-range error responses.
module adbg_lint_mem_target #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            AUX_WIDTH  = 6,
  parameter int unsigned            MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
  input  logic                      clk_i,
  input  logic                      trstn_i,
  input  logic                      lint_req_i,
  input  logic [ADDR_WIDTH-1:0]     lint_add_i,
  input  logic                      lint_wen_i,
  input  logic [DATA_WIDTH-1:0]     lint_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   lint_be_i,
  input  logic [AUX_WIDTH-1:0]      lint_aux_i,
  input  logic [3:0]                wait_cycles_i,
  output logic                      lint_gnt_o,
  output logic                      lint_r_valid_o,
  output logic [DATA_WIDTH-1:0]     lint_r_rdata_o,
  output logic [AUX_WIDTH-1:0]      lint_r_aux_o,
  output logic                      lint_r_opc_o
);

  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(BE_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned HI_LSB = OFF_W + IDX_W;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [3:0]            r_wcnt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [AUX_WIDTH-1:0]  r_aux;
  logic                  r_opc;

  logic [ADDR_WIDTH:0]   w_off;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_gnt;
  logic                  w_unused_off;

  // Extra top bit of the subtraction flags addresses below BASE_ADDR.
  assign w_off        = {1'b0, lint_add_i} - {1'b0, BASE_ADDR};
  assign w_in_range   = ~w_off[ADDR_WIDTH] & ~(|w_off[ADDR_WIDTH-1:HI_LSB]);
  assign w_idx        = w_off[HI_LSB-1:OFF_W];
  assign w_unused_off = ^w_off[OFF_W-1:0];

  assign w_gnt      = trstn_i & lint_req_i & (r_wcnt >= wait_cycles_i);
  assign lint_gnt_o = w_gnt;

  // Saturating wait-state counter, cleared on grant or idle.
  always_ff @(posedge clk_i or negedge trstn_i) begin
    if (!trstn_i) begin
      r_wcnt <= 4'd0;
    end else if (!lint_req_i || w_gnt) begin
      r_wcnt <= 4'd0;
    end else if (r_wcnt != 4'hF) begin
      r_wcnt <= r_wcnt + 4'd1;
    end
  end

  // Memory array is not reset.
  always_ff @(posedge clk_i) begin
    if (w_gnt && !lint_wen_i && w_in_range) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (lint_be_i[i]) begin
          r_mem[w_idx][8*i +: 8] <= lint_wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge trstn_i) begin
    if (!trstn_i) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_aux   <= '0;
      r_opc   <= 1'b0;
    end else begin
      r_valid <= w_gnt;
      if (w_gnt) begin
        r_aux   <= lint_aux_i;
        r_opc   <= ~w_in_range;
        r_rdata <= (lint_wen_i && w_in_range) ? r_mem[w_idx] : '0;
      end
    end
  end

  assign lint_r_valid_o = r_valid;
  assign lint_r_rdata_o = r_rdata;
  assign lint_r_aux_o   = r_aux;
  assign lint_r_opc_o   = r_opc;

endmodule

// File: doc/adbg_lint_mem_target.md
# adbg_lint_mem_target

LINT responder (target side of the debug-unit LINT bus) that serves single-beat read/write requests from a word-addressed on-chip memory with byte enables, programmable grant wait-states and out-of-range error signalling. Sits on the interconnect opposite the debug BIU's LINT initiator port. Used as a debug scratchpad and as the standard bench target for initiator verification.

## Interface
- ADDR_WIDTH, 32, request address width (byte address)
- DATA_WIDTH, 64, data width; 32 or 64 only
- AUX_WIDTH, 6, request/response aux tag width
- MEM_DEPTH, 256, number of DATA_WIDTH words; power of two, ≥2
- BASE_ADDR, 32'h0, byte address of word 0; aligned to MEM_DEPTH*DATA_WIDTH/8
- clk_i  in  1  clock
- trstn_i  in  1  reset, asynchronous, active-low
- lint_req_i  in  1  request valid; initiator holds it, with all request fields stable, until granted
- lint_add_i  in  ADDR_WIDTH  byte address
- lint_wen_i  in  1  0 = write, 1 = read
- lint_wdata_i  in  DATA_WIDTH  write data
- lint_be_i  in  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i]
- lint_aux_i  in  AUX_WIDTH  request tag
- wait_cycles_i  in  4  grant wait-states per request (quasi-static)
- lint_gnt_o  out  1  grant (combinational)
- lint_r_valid_o  out  1  response valid, one cycle
- lint_r_rdata_o  out  DATA_WIDTH  read data
- lint_r_aux_o  out  AUX_WIDTH  echoed tag
- lint_r_opc_o  out  1  1 = error (address out of range)

## Operation
- Word index = (lint_add_i − BASE_ADDR) >> log2(DATA_WIDTH/8). In range iff BASE_ADDR ≤ add < BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8. Low byte-offset bits are ignored; byte lanes are selected by lint_be_i only.
- Wait counter wcnt, 4 bits, saturating. It increments each cycle lint_req_i=1 and no grant is given. It clears on grant and whenever lint_req_i=0.
- lint_gnt_o = trstn_i & lint_req_i & (wcnt ≥ wait_cycles_i). The comparison is ≥, so lowering wait_cycles_i mid-wait grants immediately.
- Access is performed on the clk_i edge that ends the grant cycle:
  - Write, in range: mem[idx] byte lane i ← wdata lane i where be[i]=1; other lanes unchanged.
  - Read, in range: rdata ← mem[idx], full word, be ignored.
  - Out of range: no memory update; rdata ← 0; opc ← 1.
- Response register, loaded at the grant edge, presented the following cycle:
  - r_valid=1
  - r_aux ← lint_aux_i
  - opc ← 0 if in range, else 1
  - rdata ← 0 for writes
- Pipelined operation: the response cycle may coincide with the next grant. Sustained throughput is 1 request/cycle when wait_cycles_i=0. No response backpressure exists.
- Read-after-write to the same word in consecutive grants returns the newly written data.
- Memory contents are not reset. Reads of unwritten words return X in simulation; the bench initialises memory before checking reads.

## Timing
- Reset values: lint_gnt_o=0, lint_r_valid_o=0, lint_r_rdata_o=0, lint_r_aux_o=0, lint_r_opc_o=0, wcnt=0.
- Request first seen in cycle N with wait_cycles_i=k: grant in cycle N+k, r_valid in cycle N+k+1 for exactly 1 cycle.
- Between responses, r_valid=0 while r_rdata/r_aux/r_opc hold their last values.
- Reset asserted mid-operation: a pending response is dropped and all outputs go to reset values asynchronously. After deassertion, the first request is granted after wait_cycles_i cycles.
- lint_req_i dropped before grant (protocol violation): no access, wcnt clears, no response.
- wait_cycles_i=15 with wcnt saturated at 15: grant in cycle N+15.

## Test plan
- Write then read, wait=0, DATA_WIDTH=64: write 0x1122334455667788, be=8'hFF, to BASE+0x10; read the same address -> grants in consecutive cycles; read response rdata=0x1122334455667788, opc=0; the write response has rdata=0.
- Byte-enable merge: preload word 3 with 0xFFFF_FFFF_FFFF_FFFF; write 0 with be=8'h0C -> read returns 0xFFFF_FFFF_0000_FFFF.
- Wait-states: wait_cycles_i=3, read request raised at cycle 10 -> gnt at cycle 13 only, r_valid at cycle 14, r_aux equals the request aux (e.g. 6'h2A).
- Out of range: read at BASE + MEM_DEPTH*8 -> granted, r_opc=1, rdata=0; a write there leaves every word unchanged, checked by full readback.
- Back-to-back burst: 16 reads to words 0..15, wait=0, req held high -> 16 consecutive grant cycles, 16 consecutive r_valid cycles lagging by 1, data in order.
- Reset mid-operation: assert trstn_i low in the grant cycle of a read -> no r_valid after release, outputs 0; the next request completes normally.
